// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort sequencer: state encoding and
// default block geometry.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_e;

  localparam int SORT_DEPTH     = 8;
  localparam int SORT_DATAWIDTH = 32;

endpackage : sort_pkg

// File: rtl/sort_gt.sv
// Unsigned greater-than comparator shared by the sort sequencer.
// c[0] is high when a is strictly greater than b.
module sort_gt #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [0:0]           c
);

  // Strict compare keeps equal words in place, which makes the sort stable.
  always_comb begin
    c[0] = (a > b);
  end

endmodule : sort_gt

// File: rtl/sort_seq_ctrl.sv
// Bubble-sort sequencer: loads DEPTH words, sorts them in place with one
// compare per cycle, then streams them out in ascending order.
// Optional feature macro: SORT_EARLY_EXIT_EN (stop after a pass with no swaps).
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int DATAWIDTH = SORT_DATAWIDTH,
  parameter int DEPTH     = SORT_DEPTH,
  parameter int ADDRW     = $clog2(SORT_DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  input  logic                 out_ready
);

  localparam logic [ADDRW:0]   CNT_FULL = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0]   CNT_LAST = (ADDRW+1)'(DEPTH-1);
  localparam logic [ADDRW-1:0] IDX_LAST = ADDRW'(DEPTH-2);

  sort_state_e          state_q;
  logic [ADDRW:0]       cnt_q;
  logic [ADDRW:0]       rd_q;
  logic [ADDRW-1:0]     pass_q;
  logic [ADDRW-1:0]     idx_q;
  logic [ADDRW-1:0]     idx_nx;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 out_valid_q;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] cmp_a;
  logic [DATAWIDTH-1:0] cmp_b;
  logic [0:0]           gt_c;
  logic                 load_fire;
  logic                 swap;
  logic                 early_exit;

  assign idx_nx    = idx_q + ADDRW'(1);
  assign cmp_a     = mem[idx_q];
  assign cmp_b     = mem[idx_nx];
  assign load_fire = (state_q == IDLE) && in_valid && in_ready_q;
  assign swap      = (state_q == SORT) && gt_c[0];

  sort_gt #(
    .DATAWIDTH(DATAWIDTH)
  ) u_gt (
    .a(cmp_a),
    .b(cmp_b),
    .c(gt_c)
  );

`ifdef SORT_EARLY_EXIT_EN
  logic swapped_q;

  // A pass with no swap (including the pair compared on its final cycle)
  // means the block is already ordered.
  assign early_exit = !(swapped_q || swap);

  // Track whether the current pass has swapped anything; cleared at pass end.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      swapped_q <= 1'b0;
    end else if (state_q != SORT || idx_q == IDX_LAST) begin
      swapped_q <= 1'b0;
    end else if (swap) begin
      swapped_q <= 1'b1;
    end
  end
`else
  assign early_exit = 1'b0;
`endif

  // Buffer writes: upstream loads in IDLE, pairwise swaps in SORT.
  always_ff @(posedge Clk) begin
    if (load_fire) begin
      mem[cnt_q[ADDRW-1:0]] <= in_data;
    end else if (swap) begin
      mem[idx_q]  <= cmp_b;
      mem[idx_nx] <= cmp_a;
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      pass_q      <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_fire) begin
            cnt_q      <= cnt_q + (ADDRW+1)'(1);
            in_ready_q <= (cnt_q != CNT_LAST);
          end else if (start && cnt_q == CNT_FULL) begin
            state_q    <= SORT;
            pass_q     <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SORT: begin
          if (idx_q == IDX_LAST) begin
            idx_q  <= '0;
            pass_q <= pass_q + ADDRW'(1);
            if (pass_q == IDX_LAST || early_exit) begin
              state_q     <= DRAIN;
              done_q      <= 1'b1;
              out_valid_q <= 1'b1;
              rd_q        <= '0;
            end
          end else begin
            idx_q <= idx_nx;
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            if (rd_q == CNT_LAST) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              rd_q        <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              rd_q <= rd_q + (ADDRW+1)'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? mem[rd_q[ADDRW-1:0]] : '0;

endmodule : sort_seq_ctrl

// File: tb/tb_sort_seq_ctrl.sv
// Testbench for sort_seq_ctrl at DEPTH=4: table of sort blocks plus
// hand-written reset-in-sort sequence, with an output scoreboard queue.
module tb_sort_seq_ctrl;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  sort_seq_ctrl #(.DATAWIDTH(DW), .DEPTH(D), .ADDRW(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nswaps = 0;
  always @(posedge Clk) if (dut.swap) nswaps <= nswaps + 1;

  int nerr = 0;
  int nchk = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [7:0]       lat;
    logic [3:0]       pat;
    logic             illegal;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [31:0] a, b, c, d,
                              input int lat, input logic [3:0] pat,
                              input logic ill);
    vec_t v;
    v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.lat = 8'(lat); v.pat = pat; v.illegal = ill;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_in_ready"},  in_ready,  1);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_done"},      done,      0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"},  out_data,  0);
  endtask

  task automatic load_words(input vec_t v, input int r);
    for (int i = 0; i < D; i++) begin
      if (v.illegal && i == 2) begin
        in_valid = 0;
        start    = 1;
        tick();
        start = 0;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("r%0d_early_start_busy", r), busy, 0);
          chk($sformatf("r%0d_early_start_in_ready", r), in_ready, 1);
          tick();
        end
      end
      chk($sformatf("r%0d_load_in_ready%0d", r, i), in_ready, 1);
      in_valid = 1;
      in_data  = v.w[i];
      start    = v.illegal && (i == D-1);
      tick();
    end
    in_valid = 0;
    start    = 0;
  endtask

  task automatic run_block(input vec_t v, input int r);
    logic [31:0] s[4];
    logic [31:0] tmp;
    logic [31:0] held;
    logic [31:0] ev;
    int t, ninv, sw0, nx, k;
    bit hold;
    // Reference: insertion sort and inversion count of the loaded block.
    for (int i = 0; i < D; i++) s[i] = v.w[i];
    ninv = 0;
    for (int i = 0; i < D; i++)
      for (int j = i + 1; j < D; j++)
        if (v.w[i] > v.w[j]) ninv++;
    for (int i = 1; i < D; i++) begin
      tmp = s[i];
      k = i - 1;
      while (k >= 0 && s[k] > tmp) begin
        s[k+1] = s[k];
        k--;
      end
      s[k+1] = tmp;
    end

    load_words(v, r);
    if (v.illegal) chk($sformatf("r%0d_start_with_last_load", r), busy, 0);
    chk($sformatf("r%0d_full_in_ready", r), in_ready, 0);

    // Start, with an extra in_valid that must be ignored (block full).
    in_valid = 1;
    in_data  = 32'hDEAD_BEEF;
    start    = 1;
    t   = cyc;
    sw0 = nswaps;
    for (int i = 0; i < D; i++) exp_q.push_back(s[i]);
    tick();
    start    = 0;
    in_valid = v.illegal;

    k = 0;
    while (k < 60 && !done) begin
      chk($sformatf("r%0d_sort_busy", r), busy, 1);
      chk($sformatf("r%0d_sort_in_ready", r), in_ready, 0);
      tick();
      k++;
    end
    in_valid = 0;
    if (!done) begin
      nchk++;
      nerr++;
      $display("FAIL r%0d_done_timeout: got no done, required done within 60 cycles", r);
    end else begin
      chk($sformatf("r%0d_done_latency", r), cyc - t, 32'(v.lat));
      chk($sformatf("r%0d_swap_count", r), nswaps - sw0, ninv);
    end

    nx = 0;
    hold = 0;
    held = '0;
    k = 0;
    while (k < 40 && nx < D) begin
      out_ready = v.pat[k % 4];
      if (k == 1) chk($sformatf("r%0d_done_pulse", r), done, 0);
      chk($sformatf("r%0d_out_valid", r), out_valid, 1);
      if (hold) chk($sformatf("r%0d_held_data", r), out_data, held);
      if (out_ready) begin
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_0000;
        chk($sformatf("r%0d_out_data%0d", r, nx), out_data, ev);
        nx++;
        hold = 0;
      end else begin
        held = out_data;
        hold = 1;
      end
      tick();
      k++;
    end
    out_ready = 0;
    chk($sformatf("r%0d_transfers", r), nx, D);
    check_idle($sformatf("r%0d_after_drain", r));
  endtask

  int lat_pre;
  int lat_one;
  int t0;

  initial begin
`ifdef SORT_EARLY_EXIT_EN
    lat_pre = 4;
    lat_one = 7;
`else
    lat_pre = 10;
    lat_one = 10;
`endif
    tbl[0] = mk(7, 3, 9, 1, 10, 4'b1111, 0);
    tbl[1] = mk(5, 5, 2, 5, 10, 4'b1111, 0);
    tbl[2] = mk(4, 3, 2, 1, 10, 4'b1001, 0);
    tbl[3] = mk(6, 0, 6, 1, 10, 4'b1111, 1);
    tbl[4] = mk(32'hFFFF_FFFF, 0, 32'h8000_0000, 1, 10, 4'b0110, 0);
    tbl[5] = mk(1, 2, 3, 4, lat_pre, 4'b1111, 0);
    tbl[6] = mk(2, 1, 3, 4, lat_one, 4'b1111, 0);

    Rst = 1; in_valid = 0; in_data = '0; start = 0; out_ready = 0;
    tick();
    check_idle("reset");
    tick();
    Rst = 0;
    tick();

    for (int r = 0; r < 7; r++) run_block(tbl[r], r);

    // Reset in the middle of a sort abandons the block.
    load_words(mk(9, 1, 8, 2, 10, 4'b1111, 0), 90);
    start = 1;
    t0 = cyc;
    tick();
    start = 0;
    while (cyc < t0 + 4) tick();
    Rst = 1;
    tick();
    Rst = 0;
    check_idle("mid_reset");
    for (int k = 0; k < 12; k++) begin
      chk("mid_reset_no_done", done, 0);
      chk("mid_reset_no_out_valid", out_valid, 0);
      tick();
    end
    run_block(mk(8, 6, 4, 2, 10, 4'b1111, 0), 91);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_sort_seq_ctrl
